// File: rtl/ariane_pkg.sv
// Frontend types shared between the BTB and the update queue that feeds it.
package ariane_pkg;

  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
    logic [63:0] target_address;
  } btb_update_t;

endpackage

// File: rtl/btb_update_queue.sv
// FIFO of resolved BTB updates; push-to-output latency 1 cycle, head held while btb_busy_i, ready low only when full.
// Define BTB_UPDQ_COALESCE_EN to merge an incoming update into a queued entry with the same pc[63:1].
module btb_update_queue #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      flush_i,
  input  logic                      debug_mode_i,
  input  logic                      resolve_valid_i,
  input  logic [63:0]               resolve_pc_i,
  input  logic [63:0]               resolve_target_i,
  output logic                      resolve_ready_o,
  input  logic                      btb_busy_i,
  output ariane_pkg::btb_update_t   btb_update_o,
  output logic [$clog2(DEPTH):0]    count_o,
  output logic                      coalesced_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic [63:0]   pc_q  [DEPTH];
  logic [63:0]   pc_d  [DEPTH];
  logic [63:0]   tgt_q [DEPTH];
  logic [63:0]   tgt_d [DEPTH];

  logic push, pop, alloc, merge;

  assign resolve_ready_o = (count_q != (PW+1)'(DEPTH)) || debug_mode_i;
  assign pop   = (count_q != '0) && !btb_busy_i && !flush_i && !rst_i;
  assign push  = resolve_valid_i && resolve_ready_o && !debug_mode_i && !flush_i;
  assign alloc = push && !merge;

`ifdef BTB_UPDQ_COALESCE_EN
  logic [PW-1:0] merge_idx;
  logic          coalesced_q, coalesced_d;

  // A head entry leaving this cycle is no longer a merge target; the update allocates behind it.
  always_comb begin
    logic [PW-1:0] offs;
    merge     = 1'b0;
    merge_idx = '0;
    offs      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offs = PW'(i) - rd_ptr_q;
      if (({1'b0, offs} < count_q) &&
          (pc_q[i][63:1] == resolve_pc_i[63:1]) &&
          !((PW'(i) == rd_ptr_q) && pop)) begin
        merge     = push;
        merge_idx = PW'(i);
      end
    end
  end

  assign coalesced_d = merge;
  assign coalesced_o = coalesced_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) coalesced_q <= 1'b0;
    else       coalesced_q <= coalesced_d;
  end
`else
  assign merge       = 1'b0;
  assign coalesced_o = 1'b0;
`endif

  always_comb begin
    pc_d  = pc_q;
    tgt_d = tgt_q;
    if (alloc) begin
      pc_d[wr_ptr_q]  = resolve_pc_i;
      tgt_d[wr_ptr_q] = resolve_target_i;
    end
`ifdef BTB_UPDQ_COALESCE_EN
    if (merge) tgt_d[merge_idx] = resolve_target_i;
`endif
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (pop)   rd_ptr_d = rd_ptr_q + PW'(1);
      if (alloc) wr_ptr_d = wr_ptr_q + PW'(1);
      case ({alloc, pop})
        2'b10:   count_d = count_q + (PW+1)'(1);
        2'b01:   count_d = count_q - (PW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    pc_q  <= pc_d;
    tgt_q <= tgt_d;
  end

  assign btb_update_o.valid          = pop;
  assign btb_update_o.pc             = pc_q[rd_ptr_q];
  assign btb_update_o.target_address = tgt_q[rd_ptr_q];
  assign count_o                     = count_q;

endmodule

// File: tb/tb_btb_update_queue.sv
// Directed plus randomised bench for btb_update_queue with a queue-based reference model.
module tb_btb_update_queue;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, dbg, rv, busy;
  logic [63:0] rpc, rtgt;
  logic        ready, coal;
  logic [2:0]  cnt;
  ariane_pkg::btb_update_t upd;

  btb_update_queue #(.DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .debug_mode_i(dbg),
    .resolve_valid_i(rv), .resolve_pc_i(rpc), .resolve_target_i(rtgt),
    .resolve_ready_o(ready), .btb_busy_i(busy), .btb_update_o(upd),
    .count_o(cnt), .coalesced_o(coal)
  );

  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] tgt;
  } ent_t;

  ent_t sb[$];
  logic exp_coal;
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Checks outputs mid-cycle, then advances the model through the coming edge.
  task automatic tick();
    logic ev, er, push_m;
    int   hit;
    ent_t e;
    @(negedge clk);
    ev = (sb.size() != 0) && !busy && !flush && !rst;
    er = (sb.size() != DEPTH) || dbg;
    chk("ready", 64'(ready), 64'(er));
    chk("valid", 64'(upd.valid), 64'(ev));
    chk("count", 64'(cnt), 64'(sb.size()));
    chk("coalesced", 64'(coal), 64'(exp_coal));
    if (ev) begin
      chk("head_pc", upd.pc, sb[0].pc);
      chk("head_target", upd.target_address, sb[0].tgt);
    end
    push_m   = rv && er && !dbg && !flush;
    exp_coal = 1'b0;
    if (rst || flush) begin
      sb.delete();
    end else begin
      hit = -1;
`ifdef BTB_UPDQ_COALESCE_EN
      if (push_m)
        for (int k = 0; k < sb.size(); k++)
          if (sb[k].pc[63:1] == rpc[63:1] && !(k == 0 && ev)) hit = k;
`endif
      if (hit >= 0) begin
        e = sb[hit];
        e.tgt = rtgt;
        sb[hit] = e;
        exp_coal = 1'b1;
      end
      if (ev) void'(sb.pop_front());
      if (push_m && hit < 0) begin
        e.pc  = rpc;
        e.tgt = rtgt;
        sb.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic [63:0] pc, input logic [63:0] tgt, input logic b);
    rv = v; rpc = pc; rtgt = tgt; busy = b;
    tick();
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; dbg = 1'b0; rv = 1'b0; busy = 1'b0;
    rpc = '0; rtgt = '0; exp_coal = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Idle after reset, then single push with one-cycle latency.
    drv(0, 0, 0, 0);
    drv(1, 64'h8000_0010, 64'h8000_0100, 0);
    drv(0, 0, 0, 0);
    drv(0, 0, 0, 0);

    // Fill while busy, attempt a fifth, drain; repeat to exercise pointer wrap.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 5; i++) drv(1, 64'h1000 + 64'(r*256 + i*16), 64'h9000 + 64'(r*256 + i), 1);
      for (int i = 0; i < 5; i++) drv(0, 0, 0, 0);
    end

    // Full with pop and valid: no push this cycle, push accepted next.
    for (int i = 0; i < 4; i++) drv(1, 64'h2000 + 64'(i*16), 64'hA000 + 64'(i), 1);
    drv(1, 64'h2100, 64'hA100, 0);
    drv(1, 64'h2100, 64'hA100, 1);
    drv(0, 0, 0, 1);
    for (int i = 0; i < 5; i++) drv(0, 0, 0, 0);

    // Debug mode drops everything.
    dbg = 1'b1;
    for (int i = 0; i < 3; i++) drv(1, 64'h3000 + 64'(i*16), 64'hB000, 0);
    drv(0, 0, 0, 0);
    dbg = 1'b0;

    // Flush with a simultaneous push.
    for (int i = 0; i < 3; i++) drv(1, 64'h4000 + 64'(i*16), 64'hC000, 1);
    flush = 1'b1;
    drv(1, 64'h4100, 64'hC100, 0);
    flush = 1'b0;
    drv(0, 0, 0, 0);
    drv(0, 0, 0, 0);

    // Same PC twice while busy (merged or two entries depending on build), then drain.
    drv(1, 64'h40, 64'h100, 1);
    drv(1, 64'h40, 64'h200, 1);
    drv(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) drv(0, 0, 0, 0);

    // Matching head that pops in the same cycle must allocate; odd bit 0 still matches.
    drv(1, 64'h50, 64'h300, 1);
    drv(1, 64'h51, 64'h400, 0);
    drv(1, 64'h51, 64'h500, 1);
    for (int i = 0; i < 3; i++) drv(0, 0, 0, 0);

    // Reset with entries queued.
    drv(1, 64'h60, 64'h600, 1);
    drv(1, 64'h70, 64'h700, 1);
    rst = 1'b1;
    drv(1, 64'h80, 64'h800, 0);
    rst = 1'b0;
    drv(0, 0, 0, 0);

    // Randomised traffic over a small PC set so merges and wraps are frequent.
    for (int i = 0; i < 400; i++) begin
      flush = ($urandom_range(0, 24) == 0);
      dbg   = ($urandom_range(0, 9) == 0);
      drv($urandom_range(0, 2) != 0,
          64'h40 + 64'($urandom_range(0, 5)) * 64'h10 + 64'($urandom_range(0, 1)),
          64'($urandom), $urandom_range(0, 2) == 0);
    end
    flush = 1'b0; dbg = 1'b0;
    for (int i = 0; i < 6; i++) drv(0, 0, 0, 0);
    chk("drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
